regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int SWEEP_W  = $clog2(NUM_REGS);

   typedef enum logic [0:0] {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past the pointer, first request wins.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   localparam int IDX_W = PTR_W + 1;

   logic             found_s;
   logic [IDX_W-1:0] idx_s;

   // Walk requesters starting at ptr+1 (wrapping) and grant the first active one.
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = {1'b0, ptr} + IDX_W'(k);
         if (idx_s >= IDX_W'(NUM_REQ)) begin
            idx_s = idx_s - IDX_W'(NUM_REQ);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s[PTR_W-1:0]]) begin
            grant[idx_s[PTR_W-1:0]] = 1'b1;
            found_s                 = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-back arbiter: zeroes the register file after reset, then grants one
// requester per cycle round-robin and issues its write one cycle later.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rf_write,
   output logic [ADDR_W-1:0]         rf_write_reg,
   output logic [DATA_W-1:0]         rf_write_data,
   output logic                      init_done
);

   localparam int PTR_W = $clog2(NUM_REQ);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [SWEEP_W-1:0]  sweep_cnt_r;
   logic [PTR_W-1:0]    last_grant_r;
   logic [PTR_W-1:0]    grant_idx_s;
   logic [NUM_REQ-1:0]  grant_s;
   logic                xfer_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_data_s;

   logic                wr_nxt_s;
   logic [ADDR_W-1:0]   reg_nxt_s;
   logic [DATA_W-1:0]   data_nxt_s;
   logic                init_nxt_s;
   logic                wr_r;
   logic [ADDR_W-1:0]   reg_r;
   logic [DATA_W-1:0]   data_r;
   logic                init_r;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (last_grant_r),
      .grant (grant_s)
   );

   // Grants are only exposed while running and out of reset.
   always_comb begin
      if ((state_r == RUN) && !clr) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
      xfer_s = |req_ready;
   end

   // Pick the granted requester's address/data and its index.
   always_comb begin
      sel_addr_s  = '0;
      sel_data_s  = '0;
      grant_idx_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
            sel_data_s  = req_data[i*DATA_W +: DATA_W];
            grant_idx_s = PTR_W'(i);
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r <= SWEEP;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: leave SWEEP once the last register has been zeroed.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         SWEEP: begin
            if (sweep_cnt_r == SWEEP_W'(NUM_REGS - 1)) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = SWEEP;
            end
         end
         RUN:     state_nxt_s = RUN;
         default: state_nxt_s = SWEEP;
      endcase
   end

   // Sweep address counter, only advancing during SWEEP.
   always_ff @(posedge clk) begin
      if (clr) begin
         sweep_cnt_r <= '0;
      end else if (state_r == SWEEP) begin
         sweep_cnt_r <= sweep_cnt_r + SWEEP_W'(1);
      end else begin
         sweep_cnt_r <= '0;
      end
   end

   // Round-robin pointer moves only on a completed transfer.
   always_ff @(posedge clk) begin
      if (clr) begin
         last_grant_r <= PTR_W'(NUM_REQ - 1);
      end else if (xfer_s) begin
         last_grant_r <= grant_idx_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   // Output decode: sweep writes zeros; run issues accepted non-r0 writes.
   always_comb begin
      wr_nxt_s   = 1'b0;
      reg_nxt_s  = reg_r;
      data_nxt_s = data_r;
      init_nxt_s = init_r;
      case (state_r)
         SWEEP: begin
            wr_nxt_s   = 1'b1;
            reg_nxt_s  = ADDR_W'(sweep_cnt_r);
            data_nxt_s = '0;
            init_nxt_s = (sweep_cnt_r == SWEEP_W'(NUM_REGS - 1));
         end
         RUN: begin
            init_nxt_s = 1'b1;
            if (xfer_s && (sel_addr_s != '0)) begin
               wr_nxt_s   = 1'b1;
               reg_nxt_s  = sel_addr_s;
               data_nxt_s = sel_data_s;
            end else begin
               wr_nxt_s   = 1'b0;
            end
         end
         default: begin
            wr_nxt_s   = 1'b0;
            init_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered register-file write port and init flag.
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_r   <= 1'b0;
         reg_r  <= '0;
         data_r <= '0;
         init_r <= 1'b0;
      end else begin
         wr_r   <= wr_nxt_s;
         reg_r  <= reg_nxt_s;
         data_r <= data_nxt_s;
         init_r <= init_nxt_s;
      end
   end

   // A captured write still pending when clr arrives is dropped.
   assign rf_write      = wr_r & ~clr;
   assign rf_write_reg  = reg_r;
   assign rf_write_data = data_r;
   assign init_done     = init_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
module tb_regfile_write_arbiter;

   logic        clk;
   logic        clr;
   logic [2:0]  v;
   logic [4:0]  a [3];
   logic [31:0] d [3];
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_write;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic        init_done;

   typedef struct packed {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q [$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   mlast   = 2;

   regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
      .clk           (clk),
      .clr           (clr),
      .req_valid     (v),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .rf_write      (rf_write),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .init_done     (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_addr = '0;
      req_data = '0;
      for (int i = 0; i < 3; i++) begin
         req_addr[i*5 +: 5]   = a[i];
         req_data[i*32 +: 32] = d[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic renew(input int i);
      a[i] = 5'($urandom_range(31, 1));
      d[i] = $urandom;
   endtask

   // Raise clr for one cycle, then check the full 32-register sweep.
   task automatic do_reset();
      clr = 1'b1;
      #1;
      chk("clr_wr", {63'd0, rf_write}, 64'd0);
      chk("clr_ready", {61'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      clr = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         chk("sweep_wr", {63'd0, rf_write}, (k >= 2) ? 64'd1 : 64'd0);
         if (k >= 2) begin
            chk("sweep_reg", {59'd0, rf_write_reg}, 64'(k - 2));
            chk("sweep_data", {32'd0, rf_write_data}, 64'd0);
         end
         chk("sweep_init", {63'd0, init_done}, (k == 33) ? 64'd1 : 64'd0);
         chk("sweep_ready", {61'd0, req_ready}, 64'd0);
         if (k < 33) begin
            @(posedge clk); #1;
         end
      end
      mlast = 2;
      exp_q.delete();
   endtask

   // One RUN cycle: check grant against the model, then the write it causes.
   task automatic step(output int gi);
      logic [2:0] eg;
      logic       found;
      int         idx;
      exp_t       e;
      #1;
      eg    = '0;
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         idx = (mlast + k) % 3;
         if (!found && v[idx]) begin
            eg[idx] = 1'b1;
            found   = 1'b1;
         end
      end
      chk("ready", {61'd0, req_ready}, {61'd0, eg});
      gi = -1;
      for (int i = 0; i < 3; i++) begin
         if (eg[i]) gi = i;
      end
      if (gi >= 0) begin
         mlast = gi;
         exp_q.push_back('{we: (a[gi] != 5'd0), wreg: a[gi], wdata: d[gi]});
      end else begin
         exp_q.push_back('{we: 1'b0, wreg: 5'd0, wdata: 32'd0});
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("wr", {63'd0, rf_write}, {63'd0, e.we});
      if (e.we) begin
         chk("wr_reg", {59'd0, rf_write_reg}, {59'd0, e.wreg});
         chk("wr_data", {32'd0, rf_write_data}, {32'd0, e.wdata});
      end
      chk("init", {63'd0, init_done}, 64'd1);
   endtask

   initial begin
      int gi;
      int waited;
      int pre;
      clr = 1'b1;
      v   = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a[i] = 5'd0;
         d[i] = 32'd0;
      end
      @(posedge clk); #1;
      do_reset();

      // Single request from requester 1.
      v = 3'b010; a[1] = 5'd5; d[1] = 32'hDEADBEEF;
      step(gi);
      chk("single_gi", 64'(gi), 64'd1);
      v = 3'b000;
      step(gi);

      // Write to register 0 is accepted but not issued.
      v = 3'b100; a[2] = 5'd0; d[2] = 32'h0000_1234;
      step(gi);
      chk("r0_gi", 64'(gi), 64'd2);
      v = 3'b000;
      step(gi);

      // All three continuously valid: strict 0,1,2 rotation.
      do_reset();
      for (int i = 0; i < 3; i++) renew(i);
      v = 3'b111;
      for (int s = 0; s < 6; s++) begin
         step(gi);
         chk("rr_order", 64'(gi), 64'(s % 3));
         if (gi >= 0) renew(gi);
      end

      // Starvation: 0 and 1 hammer, 2 arrives late.
      v = 3'b011;
      pre = $urandom_range(5, 0);
      for (int s = 0; s < pre; s++) begin
         step(gi);
         if (gi >= 0) renew(gi);
      end
      renew(2);
      v[2]   = 1'b1;
      waited = 0;
      gi     = -1;
      while (gi != 2 && waited < 6) begin
         step(gi);
         waited++;
         if (gi >= 0 && gi != 2) renew(gi);
      end
      chk("starve", {63'd0, (waited <= 3)}, 64'd1);
      v = 3'b000;
      step(gi);

      // clr right after an accept drops the pending write.
      v = 3'b001; a[0] = 5'd7; d[0] = 32'hA5A5A5A5;
      #1;
      chk("clr_accept", {61'd0, req_ready}, 64'd1);
      @(posedge clk); #1;
      v = 3'b000;
      do_reset();
      step(gi);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
